// File: rtl/cfu_simd_pkg.sv
// Shared opcodes, FSM encoding, capture payload and width helpers for the SIMD MAC CFU.
package cfu_simd_pkg;

    localparam logic [2:0] OP_MAC   = 3'd0;
    localparam logic [2:0] OP_CLR   = 3'd1;
    localparam logic [2:0] OP_SETOF = 3'd2;
    localparam logic [2:0] OP_RD    = 3'd3;
    localparam logic [2:0] OP_WR    = 3'd4;
    localparam logic [2:0] OP_FLAG  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [9:0]  function_id;
        logic [31:0] in0;
    } cmd_cap_t;

    function automatic int unsigned lane_w(input int unsigned lanes);
        return 32 / lanes;
    endfunction

    // Full-precision dot width: (LANE_W+1)x(LANE_W) product plus log2(LANES) growth.
    function automatic int unsigned dot_w(input int unsigned lanes);
        return 2 * (32 / lanes) + 1 + $clog2(lanes);
    endfunction

    function automatic int unsigned acc_sel_w(input int unsigned num_acc);
        return (num_acc > 1) ? $clog2(num_acc) : 1;
    endfunction

endpackage

// File: rtl/cfu_simd_mac_multi_dot.sv
// Per-lane (in0 + offset) * in1 products summed at full width.
// PIPE != 0 adds a result register loaded when en is high.
module cfu_simd_dot
    import cfu_simd_pkg::*;
#(
    parameter int unsigned LANES  = 4,
    parameter int unsigned PIPE   = 0,
    localparam int unsigned LANE_W = lane_w(LANES),
    localparam int unsigned DOT_W  = dot_w(LANES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [31:0]             in0,
    input  logic [31:0]             in1,
    input  logic signed [LANE_W:0]  offset,
    output logic signed [DOT_W-1:0] dot_c
);

    logic signed [LANE_W:0]     lane_sum;
    logic signed [2*LANE_W:0]   prod;
    logic signed [DOT_W-1:0]    sum_c;

    // The offset lane sum wraps at LANE_W+1 bits; products and the sum never overflow.
    always_comb begin
        sum_c    = '0;
        lane_sum = '0;
        prod     = '0;
        for (int k = 0; k < int'(LANES); k++) begin
            lane_sum = (LANE_W+1)'(signed'(in0[k*LANE_W +: LANE_W])) + offset;
            prod     = (2*LANE_W+1)'(lane_sum) * (2*LANE_W+1)'(signed'(in1[k*LANE_W +: LANE_W]));
            sum_c    = sum_c + DOT_W'(prod);
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            logic signed [DOT_W-1:0] dot_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    dot_q <= '0;
                end else if (en) begin
                    dot_q <= sum_c;
                end
            end
            assign dot_c = dot_q;
        end else begin : g_comb
            logic unused_ctl;
            assign unused_ctl = ^{clk, reset, en};
            assign dot_c      = sum_c;
        end
    endgenerate

endmodule

// File: rtl/cfu_simd_mac_multi.sv
// SIMD multiply-accumulate CFU with NUM_ACC per-command selectable accumulators.
// Define CFU_SIMD_SATURATE_EN for saturating MAC results and a sticky overflow flag (opcode 5).
module cfu_simd_mac_multi
    import cfu_simd_pkg::*;
#(
    parameter int unsigned LANES          = 4,
    parameter int unsigned NUM_ACC        = 4,
    parameter int          DEFAULT_OFFSET = 128,
    parameter int unsigned PIPE           = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    localparam int unsigned LANE_W    = lane_w(LANES);
    localparam int unsigned DOT_W     = dot_w(LANES);
    localparam int unsigned ACC_SEL_W = acc_sel_w(NUM_ACC);
    localparam int unsigned EXT_W     = ((DOT_W > 32) ? DOT_W : 32) + 1;

    state_t                  state;
    state_t                  next_state;
    logic                    accept_c;
    logic                    wb_fire_c;
    cmd_cap_t                cap;
    logic [9:0]              wb_fid;
    logic [31:0]             wb_in0;
    logic [2:0]              funct3;
    logic [ACC_SEL_W-1:0]    sel;
    logic                    sel_ok;
    logic signed [LANE_W:0]  offset;
    logic signed [DOT_W-1:0] dot;
    logic [31:0]             acc [NUM_ACC];
    logic [31:0]             acc_cur;
    logic [31:0]             acc_wdata;
    logic                    acc_we;
    logic                    off_we;
    logic [31:0]             result;
    logic signed [EXT_W-1:0] mac_sum;
    logic [31:0]             mac_res;
    logic                    unused_fid;

    // Next-state logic; only one command may be outstanding.
    always_comb begin
        next_state = state;
        accept_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    accept_c   = 1'b1;
                    next_state = (PIPE != 0) ? ST_MUL : ST_RESP;
                end
            end
            ST_MUL:  next_state = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign wb_fire_c = (state != ST_RESP) && (next_state == ST_RESP);

    // Without the multiply stage, writeback happens in the accept cycle straight off the bus.
    assign wb_fid     = (PIPE != 0) ? cap.function_id : cmd_payload_function_id;
    assign wb_in0     = (PIPE != 0) ? cap.in0 : cmd_payload_inputs_0;
    assign funct3     = wb_fid[2:0];
    assign sel        = wb_fid[3 +: ACC_SEL_W];
    assign unused_fid = ^wb_fid[9:3+ACC_SEL_W];

    cfu_simd_dot #(
        .LANES (LANES),
        .PIPE  (PIPE)
    ) u_dot (
        .clk    (clk),
        .reset  (reset),
        .en     (accept_c),
        .in0    (cmd_payload_inputs_0),
        .in1    (cmd_payload_inputs_1),
        .offset (offset),
        .dot_c  (dot)
    );

    always_comb begin
        acc_cur = '0;
        sel_ok  = 1'b0;
        for (int i = 0; i < int'(NUM_ACC); i++) begin
            if (ACC_SEL_W'(i) == sel) begin
                acc_cur = acc[i];
                sel_ok  = 1'b1;
            end
        end
    end

    assign mac_sum = EXT_W'(signed'(acc_cur)) + EXT_W'(dot);

`ifdef CFU_SIMD_SATURATE_EN
    logic flag;
    logic mac_ovf_c;

    // Overflow when bits above bit 31 are not a pure sign extension.
    assign mac_ovf_c = !((&mac_sum[EXT_W-1:31]) || !(|mac_sum[EXT_W-1:31]));
    assign mac_res   = !mac_ovf_c ? mac_sum[31:0]
                     : (mac_sum[EXT_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            flag <= 1'b0;
        end else if (wb_fire_c && sel_ok) begin
            if ((funct3 == OP_MAC) && mac_ovf_c) begin
                flag <= 1'b1;
            end else if (funct3 == OP_CLR) begin
                flag <= 1'b0;
            end
        end
    end
`else
    logic unused_sum;
    assign unused_sum = ^mac_sum[EXT_W-1:32];
    assign mac_res    = mac_sum[31:0];
`endif

    // Opcode decode: response value and side effects; an out-of-range select does nothing.
    always_comb begin
        acc_we    = 1'b0;
        acc_wdata = '0;
        off_we    = 1'b0;
        result    = '0;
        if (sel_ok) begin
            case (funct3)
                OP_MAC: begin
                    acc_we    = 1'b1;
                    acc_wdata = mac_res;
                    result    = mac_res;
                end
                OP_CLR: begin
                    acc_we    = 1'b1;
                    acc_wdata = '0;
                    result    = acc_cur;
                end
                OP_SETOF: begin
                    off_we = 1'b1;
                    result = 32'(offset);
                end
                OP_RD: result = acc_cur;
                OP_WR: begin
                    acc_we    = 1'b1;
                    acc_wdata = wb_in0;
                    result    = wb_in0;
                end
`ifdef CFU_SIMD_SATURATE_EN
                OP_FLAG: result = {31'b0, flag};
`endif
                default: result = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_ACC); i++) begin
                acc[i] <= '0;
            end
            offset <= (LANE_W+1)'(DEFAULT_OFFSET);
        end else if (wb_fire_c) begin
            if (acc_we) begin
                for (int i = 0; i < int'(NUM_ACC); i++) begin
                    if (ACC_SEL_W'(i) == sel) begin
                        acc[i] <= acc_wdata;
                    end
                end
            end
            if (off_we) begin
                offset <= (LANE_W+1)'(signed'(wb_in0));
            end
        end
    end

    // State register, handshake outputs and response payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= ST_IDLE;
            cmd_ready             <= 1'b1;
            rsp_valid             <= 1'b0;
            rsp_payload_outputs_0 <= '0;
            cap                   <= '0;
        end else begin
            state     <= next_state;
            cmd_ready <= (next_state == ST_IDLE);
            rsp_valid <= (next_state == ST_RESP);
            if (accept_c) begin
                cap <= '{function_id: cmd_payload_function_id, in0: cmd_payload_inputs_0};
            end
            if (wb_fire_c) begin
                rsp_payload_outputs_0 <= result;
            end
        end
    end

endmodule
